// File: rtl/dmrs_pkg.sv
// Shared types and constants for the NB-IoT uplink DMRS generator.
// Combinational only: no latency, no backpressure.
// Elaboration-time helpers; nothing here is clocked.
package dmrs_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic MODE_BPSK = 1'b0;
    localparam logic MODE_QPSK = 1'b1;

    localparam logic [31:0] FP_POS_INV_SQRT2 = 32'h3F3504F3;
    localparam logic [31:0] FP_NEG_INV_SQRT2 = 32'hBF3504F3;

    // 1/sqrt(2) in unsigned Q0.32, rounded.
    localparam logic [63:0] INV_SQRT2_Q32 = 64'd3037000500;

    // round(2^(dw-1) / sqrt(2)); valid for dw up to 32.
    function automatic logic [31:0] fix_amp(input int dw);
        logic [63:0] p;
        p = (INV_SQRT2_Q32 << (dw - 1)) + 64'h0000_0000_8000_0000;
        return p[63:32];
    endfunction

endpackage

// File: rtl/gold_lfsr.sv
// Gold-sequence generator: x1/x2 LFSR pair, load or advance by 1 or 2 steps per cycle.
// c0/c1 are combinational from the registered state; a step takes effect on the next edge.
// No backpressure of its own: the owner gates step.
module gold_lfsr (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic        two,
    input  logic [30:0] cinit,
    output logic        c0,
    output logic        c1
);

    logic [30:0] x1, x2;
    logic [30:0] x1_1, x2_1, x1_2, x2_2;

    // Bit k of each register holds x(n+k); a step shifts right and appends x(n+31).
    assign x1_1 = {x1[3] ^ x1[0], x1[30:1]};
    assign x2_1 = {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};
    assign x1_2 = {x1_1[3] ^ x1_1[0], x1_1[30:1]};
    assign x2_2 = {x2_1[3] ^ x2_1[2] ^ x2_1[1] ^ x2_1[0], x2_1[30:1]};

    assign c0 = x1[0] ^ x2[0];
    assign c1 = x1[1] ^ x2[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x1 <= 31'h1;
            x2 <= '0;
        end else if (load) begin
            x1 <= 31'h1;
            x2 <= cinit;
        end else if (step) begin
            x1 <= two ? x1_2 : x1_1;
            x2 <= two ? x2_2 : x2_1;
        end
    end

endmodule

// File: rtl/dmrs_seq_gen.sv
// NB-IoT uplink DMRS generator: NCH segments of SEQ_LEN BPSK/QPSK symbols; DMRS_FLOAT_OUT_EN selects IEEE-754 outputs.
// First out_valid NC+1 cycles after start, then one symbol per cycle while out_ready is high.
// out_ready low holds the current symbol, indices and out_valid stable; the LFSRs advance only on handshake.
module dmrs_seq_gen
    import dmrs_pkg::*;
#(
    parameter  int DW      = 16,
    parameter  int NCH     = 2,
    parameter  int SEQ_LEN = 10240,
    parameter  int NC      = 1600,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int IW      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [30:0]   cinit,
    input  logic          mode,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef DMRS_FLOAT_OUT_EN
    output logic [31:0]   out_i,
    output logic [31:0]   out_q,
`else
    output logic [DW-1:0] out_i,
    output logic [DW-1:0] out_q,
`endif
    output logic [CW-1:0] out_ch,
    output logic [IW-1:0] out_idx,
    output logic          busy,
    output logic          done
);

    localparam int WW = ($clog2(NC + 1) > 0) ? $clog2(NC + 1) : 1;

    state_t        state, state_n;
    logic          mode_q;
    logic [WW-1:0] warm_cnt;
    logic          warm_done, hs, last, load, step, two;
    logic          c0, c1, bit_i, bit_q;

    assign hs        = out_valid && out_ready;
    assign last      = (out_ch == CW'(NCH - 1)) && (out_idx == IW'(SEQ_LEN - 1));
    assign warm_done = (warm_cnt == WW'(NC));
    assign load      = (state == IDLE) && start && !abort;
    // The WARMUP state lasts NC+1 cycles but only the first NC of them step the LFSRs.
    assign step      = !abort && (((state == WARMUP) && !warm_done) || hs);
    assign two       = (state == RUN) && (mode_q == MODE_QPSK);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start)      state_n = WARMUP;
            WARMUP:  if (warm_done)  state_n = RUN;
            RUN:     if (hs && last) state_n = DONE;
            DONE:                    state_n = IDLE;
            default:                 state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mode_q   <= MODE_BPSK;
            warm_cnt <= '0;
            out_ch   <= '0;
            out_idx  <= '0;
        end else begin
            state <= state_n;
            if (load) mode_q <= mode;

            if (abort || load)
                warm_cnt <= '0;
            else if ((state == WARMUP) && !warm_done)
                warm_cnt <= warm_cnt + 1'b1;

            if (abort || load || (hs && last)) begin
                out_ch  <= '0;
                out_idx <= '0;
            end else if (hs) begin
                if (out_idx == IW'(SEQ_LEN - 1)) begin
                    out_idx <= '0;
                    out_ch  <= out_ch + 1'b1;
                end else begin
                    out_idx <= out_idx + 1'b1;
                end
            end
        end
    end

    gold_lfsr u_gold (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .two   (two),
        .cinit (cinit),
        .c0    (c0),
        .c1    (c1)
    );

    assign out_valid = (state == RUN);
    assign busy      = (state == WARMUP) || (state == RUN);
    assign done      = (state == DONE);

    // BPSK puts c(n) on both rails; QPSK uses c(2n) on I and c(2n+1) on Q.
    assign bit_i = c0;
    assign bit_q = (mode_q == MODE_QPSK) ? c1 : c0;

`ifdef DMRS_FLOAT_OUT_EN
    assign out_i = out_valid ? (bit_i ? FP_NEG_INV_SQRT2 : FP_POS_INV_SQRT2) : '0;
    assign out_q = out_valid ? (bit_q ? FP_NEG_INV_SQRT2 : FP_POS_INV_SQRT2) : '0;
`else
    localparam logic [DW-1:0] A_POS = DW'(fix_amp(DW));
    localparam logic [DW-1:0] A_NEG = '0 - A_POS;

    assign out_i = out_valid ? (bit_i ? A_NEG : A_POS) : '0;
    assign out_q = out_valid ? (bit_q ? A_NEG : A_POS) : '0;
`endif

endmodule

// File: doc/dmrs_seq_gen.md
Name: dmrs_seq_gen

Overview:
Parametrised NB-IoT uplink DMRS generator for the transmitter chain.
- Holds its own Gold-sequence generator, with LFSRs x1/x2 and a warm-up of NC steps.
- Maps c(n) to BPSK or QPSK reference symbols at ±1/√2.
- Streams NCH consecutive channel segments of SEQ_LEN symbols each through a valid/ready handshake, ahead of resource mapping.

Parameters:
- DW, 16: fixed-point output width, signed Q1.(DW-1).
- NCH, 2: number of channel segments emitted per start, ≥1.
- SEQ_LEN, 10240: symbols per channel segment, ≥1.
- NC, 1600: Gold-sequence warm-up offset, in LFSR steps.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a generation run; sampled only in IDLE.
- abort, in, 1: synchronous abort; wins over every other input.
- cinit, in, 31: x2 initial state, latched on start.
- mode, in, 1: 0 = BPSK, 1 = QPSK; latched on start.
- out_valid, out, 1: symbol valid.
- out_ready, in, 1: downstream accept.
- out_i, out, DW: in-phase symbol.
- out_q, out, DW: quadrature symbol.
- out_ch, out, clog2(NCH) (min 1): channel index of the current symbol.
- out_idx, out, clog2(SEQ_LEN) (min 1): symbol index within the segment.
- busy, out, 1: high in WARMUP and RUN.
- done, out, 1: one-cycle pulse after the last symbol is accepted.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; x1=1, x2=0; out_valid, out_i, out_q, out_ch, out_idx, busy, done all 0.
- LFSR recurrences: x1(n+31)=x1(n+3)^x1(n); x2(n+31)=x2(n+3)^x2(n+2)^x2(n+1)^x2(n); c(n)=x1(n)^x2(n), taken after warm-up.
- IDLE: on start=1, latch cinit and mode, load x1=31'h1 and x2=cinit, go to WARMUP.
- WARMUP: advance one LFSR step per cycle for exactly NC cycles. Then go to RUN with out_valid=1 on the next cycle. Latency from start to first valid is NC+1 cycles.
- RUN symbol mapping, A=round(0.70710678·2^(DW-1)) (23170 for DW=16):
  - BPSK: out_i=out_q=(1-2c(n))·A.
  - QPSK: out_i=(1-2c(2n))·A, out_q=(1-2c(2n+1))·A.
  - Negative values are two's complement.
- Advance: only when out_valid && out_ready. BPSK steps the LFSRs 1 per handshake, QPSK 2 per handshake, computed combinationally in one cycle.
- Stall: with out_ready=0, out_i, out_q, out_ch and out_idx hold stable and out_valid stays 1.
- Counters:
  - out_idx wraps from SEQ_LEN-1 to 0 and increments out_ch.
  - The sequence continues across segments with no re-seed.
  - On the handshake of (ch=NCH-1, idx=SEQ_LEN-1), go to DONE.
- DONE: one cycle with done=1, out_valid=0, busy=0, then IDLE.
- start while busy: ignored. mode/cinit changes while busy: ignored.
- abort=1 in any state: next cycle state=IDLE, out_valid=0, counters cleared, no done pulse.
- Simultaneous abort and start in IDLE: abort wins and stays IDLE.
- Reset mid-run: asynchronous return to the reset values above.

Optional Feature:
- Macro: DMRS_FLOAT_OUT_EN.
- Defined: out_i/out_q are 32-bit IEEE-754 single precision, and DW is ignored for these ports. +A=32'h3F3504F3, -A=32'hBF3504F3, 0 is not produced.
- Undefined: DW-bit fixed point as specified above.
- Handshake, timing and all other behaviour are identical in both builds.

Decomposition:
- Package dmrs_pkg:
  - State encoding: IDLE, WARMUP, RUN, DONE.
  - Mode constants: MODE_BPSK=0, MODE_QPSK=1.
  - Float constants: FP_POS_INV_SQRT2, FP_NEG_INV_SQRT2.
  - Function computing the fixed-point A from DW.
- Sub-module gold_lfsr:
  - Holds x1/x2 with load and step enables.
  - Step count selectable 1 or 2 per cycle.
  - Exposes c0, the current bit, and c1, the next bit.
- Top level holds the FSM, counters, mapper and handshake.

Test Plan:
- Reset: assert reset=0 mid-RUN → all outputs 0 immediately; after release, busy=0 and out_valid=0.
- Latency and segmentation (NC=1600, SEQ_LEN=8, NCH=2, BPSK, cinit=0, out_ready=1):
  - First out_valid exactly 1601 cycles after start.
  - 16 symbols, out_ch switches 0→1 after idx 7.
  - done pulses one cycle after the 16th handshake.
  - Symbols equal ±23170 (16'h5A82 / 16'hA57E) matching the golden c(n).
- QPSK with cinit=31'h1234567: out_i/out_q pairs match the golden c(2n)/c(2n+1) for 64 symbols, with LFSR consumption of 2 bits per symbol verified.
- Backpressure: random out_ready (50%), including a 5-cycle stall → outputs held stable during the stall, no symbol lost or duplicated versus the golden stream.
- Abort and ignored start:
  - abort during WARMUP → IDLE next cycle, no done.
  - abort at idx 3 of RUN → out_valid falls next cycle.
  - start while busy → ignored, run completes normally.
- DMRS_FLOAT_OUT_EN build: same stimulus as the BPSK test → outputs are only 32'h3F3504F3 / 32'hBF3504F3, in the same sign pattern as the fixed build.
